// File: rtl/rx_frame_deserializer_pkg.sv
// Shared widths, defaults and state type for the RX frame deserializer.
package rx_frame_deserializer_pkg;

    localparam int DEF_SYM_W          = 3;
    localparam int DEF_SYMS_PER_FRAME = 128;
    localparam int DEF_DONE_TIMEOUT   = 1023;
    localparam int DEF_FRAME_W        = DEF_SYM_W * DEF_SYMS_PER_FRAME;
    localparam int FRAME_CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DECODE  = 2'd1,
        ST_OUTPUT  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/rx_frame_deserializer_if.sv
// Symbol-in / decoder / frame-out bundle; slave is the deserializer's view, master the driver's.
interface rx_frame_deserializer_if
    import rx_frame_deserializer_pkg::*;
#(
    parameter int SYM_W          = DEF_SYM_W,
    parameter int SYMS_PER_FRAME = DEF_SYMS_PER_FRAME
);
    logic                              i_code_rate;
    logic [SYM_W-1:0]                  i_sym;
    logic                              i_sym_valid;
    logic                              o_sym_ready;
    logic [SYM_W*SYMS_PER_FRAME-1:0]   o_decoder_data_frame;
    logic                              o_en;
    logic [SYMS_PER_FRAME-1:0]         i_decoder_data;
    logic                              i_decoder_done;
    logic [SYMS_PER_FRAME-1:0]         o_data;
    logic                              o_data_valid;
    logic                              i_data_ready;
    logic                              o_timeout;
    logic [FRAME_CNT_W-1:0]            o_frame_cnt;

    modport slave (
        input  i_code_rate, i_sym, i_sym_valid, i_decoder_data, i_decoder_done, i_data_ready,
        output o_sym_ready, o_decoder_data_frame, o_en, o_data, o_data_valid, o_timeout, o_frame_cnt
    );

    modport master (
        output i_code_rate, i_sym, i_sym_valid, i_decoder_data, i_decoder_done, i_data_ready,
        input  o_sym_ready, o_decoder_data_frame, o_en, o_data, o_data_valid, o_timeout, o_frame_cnt
    );
endinterface

// File: rtl/rx_frame_deserializer.sv
// Packs SYMS_PER_FRAME symbols into a decoder frame, runs the decoder with a timeout, holds the result.
// Latency: DECODE one cycle after the last symbol; ready only in COLLECT; o_data held until i_data_ready.
module rx_frame_deserializer
    import rx_frame_deserializer_pkg::*;
#(
    parameter int SYM_W          = DEF_SYM_W,
    parameter int SYMS_PER_FRAME = DEF_SYMS_PER_FRAME,
    parameter int DONE_TIMEOUT   = DEF_DONE_TIMEOUT
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    rx_frame_deserializer_if.slave bus
);

    localparam int FRAME_W = SYM_W * SYMS_PER_FRAME;
    localparam int IDX_W   = $clog2(SYMS_PER_FRAME);
    localparam int TMO_W   = $clog2(DONE_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_FRAME - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);
    // Rate 1/2 carries no third generator output, so the top symbol bit is forced to 0.
    localparam logic [SYM_W-1:0] HALF_MASK = {1'b0, {(SYM_W-1){1'b1}}};

    rx_state_e                 state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      rate_q, rate_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [FRAME_W-1:0]        frame_q, frame_d;
    logic [SYMS_PER_FRAME-1:0] data_q, data_d;
    logic                      data_vld_q, data_vld_d;
    logic                      timeout_q, timeout_d;
    logic [FRAME_CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic                      sym_rate;
    logic [SYM_W-1:0]          sym_bits;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rate_d      = rate_q;
        tmo_d       = tmo_q;
        frame_d     = frame_q;
        data_d      = data_q;
        data_vld_d  = data_vld_q;
        timeout_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Symbol 0 sets the frame's rate; later symbols reuse the latched value.
        sym_rate = (idx_q == '0) ? bus.i_code_rate : rate_q;
        sym_bits = sym_rate ? bus.i_sym : (bus.i_sym & HALF_MASK);

        case (state_q)
            ST_COLLECT: begin
                if (bus.i_sym_valid) begin
                    rate_d = sym_rate;
                    frame_d[idx_q*SYM_W +: SYM_W] = sym_bits;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        tmo_d   = '0;
                        state_d = ST_DECODE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                // Done is checked first so it wins over a coincident timeout expiry.
                if (bus.i_decoder_done) begin
                    data_d      = bus.i_decoder_data;
                    data_vld_d  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_OUTPUT;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    tmo_d     = '0;
                    idx_d     = '0;
                    frame_d   = '0;
                    state_d   = ST_COLLECT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (bus.i_data_ready && data_vld_q) begin
                    data_vld_d = 1'b0;
                    frame_d    = '0;
                    state_d    = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            idx_q       <= '0;
            rate_q      <= 1'b0;
            tmo_q       <= '0;
            frame_q     <= '0;
            data_q      <= '0;
            data_vld_q  <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rate_q      <= rate_d;
            tmo_q       <= tmo_d;
            frame_q     <= frame_d;
            data_q      <= data_d;
            data_vld_q  <= data_vld_d;
            timeout_q   <= timeout_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.o_sym_ready          = (state_q == ST_COLLECT);
    assign bus.o_en                 = (state_q == ST_DECODE);
    assign bus.o_decoder_data_frame = frame_q;
    assign bus.o_data               = data_q;
    assign bus.o_data_valid         = data_vld_q;
    assign bus.o_timeout            = timeout_q;
    assign bus.o_frame_cnt          = frame_cnt_q;

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Directed + randomized bench for rx_frame_deserializer against a frame/counter reference model.
module tb_rx_frame_deserializer;
    import rx_frame_deserializer_pkg::*;

    localparam int N     = 128;
    localparam int FW    = 3 * N;
    localparam int LIMIT = 200;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    rx_frame_deserializer_if bus ();

    rx_frame_deserializer #(
        .SYM_W          (3),
        .SYMS_PER_FRAME (N),
        .DONE_TIMEOUT   (1023)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_cnt;
    logic [2:0] syms  [N];
    logic       rates [N];

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as the decoder should see it: symbol k at bits 3k..3k+2, third bit
    // dropped when the rate presented with symbol 0 was 1/2.
    function automatic logic [FW-1:0] model_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++)
            for (int b = 0; b < 3; b++)
                f[3*k+b] = (b == 2 && !rates[0]) ? 1'b0 : syms[k][b];
        return f;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents symbols 0..count-1; returns at the negedge after the last acceptance.
    task automatic send_frame(input int count, input bit gaps);
        int n;
        for (int k = 0; k < count; k++) begin
            @(negedge sys_clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.i_sym_valid = 1'b0;
                @(negedge sys_clk);
            end
            n = 0;
            if (!bus.o_sym_ready) bus.i_sym_valid = 1'b0;
            while (!bus.o_sym_ready && n < LIMIT) begin
                @(negedge sys_clk);
                n++;
            end
            if (n >= LIMIT) chk("ready_wait", 0, 1);
            bus.i_sym         = syms[k];
            bus.i_code_rate   = rates[k];
            bus.i_sym_valid   = 1'b1;
        end
        @(negedge sys_clk);
        bus.i_sym_valid = 1'b0;
        bus.i_sym       = 3'($urandom);
    endtask

    // Called in DECODE cycle 1; raises done in DECODE cycle `delay`, then drains OUTPUT.
    task automatic finish_decode(input int delay, input logic [127:0] dat, input string tag);
        chk({tag, ".en_after_last"}, bus.o_en, 1'b1);
        chk({tag, ".frame"}, bus.o_decoder_data_frame, model_frame());
        repeat (delay - 1) @(negedge sys_clk);
        chk({tag, ".frame_hold"}, bus.o_decoder_data_frame, model_frame());
        bus.i_decoder_data = dat;
        bus.i_decoder_done = 1'b1;
        @(negedge sys_clk);
        bus.i_decoder_done = 1'b0;
        bus.i_decoder_data = rand128();
        exp_cnt = (exp_cnt + 1) % 65536;
        chk({tag, ".odata"}, bus.o_data, dat);
        chk({tag, ".valid"}, bus.o_data_valid, 1'b1);
        chk({tag, ".cnt"}, bus.o_frame_cnt, exp_cnt);
        chk({tag, ".no_tmo"}, bus.o_timeout, 1'b0);
        chk({tag, ".en_off"}, bus.o_en, 1'b0);
        repeat (3) @(negedge sys_clk);
        chk({tag, ".odata_hold"}, bus.o_data, dat);
        chk({tag, ".ready_low"}, bus.o_sym_ready, 1'b0);
        bus.i_data_ready = 1'b1;
        @(negedge sys_clk);
        bus.i_data_ready = 1'b0;
        chk({tag, ".valid_clr"}, bus.o_data_valid, 1'b0);
        chk({tag, ".ready_back"}, bus.o_sym_ready, 1'b1);
        chk({tag, ".frame_zero"}, bus.o_decoder_data_frame, '0);
    endtask

    initial begin
        logic [FW-1:0] exp_a;
        bit en_all, tmo_seen;

        rst                = 1'b1;
        bus.i_code_rate    = 1'b0;
        bus.i_sym          = '0;
        bus.i_sym_valid    = 1'b0;
        bus.i_decoder_data = '0;
        bus.i_decoder_done = 1'b0;
        bus.i_data_ready   = 1'b0;
        exp_cnt            = 0;

        #12;
        chk("rst.sym_ready", bus.o_sym_ready, 1'b1);
        chk("rst.frame", bus.o_decoder_data_frame, '0);
        chk("rst.en", bus.o_en, 1'b0);
        chk("rst.data", bus.o_data, '0);
        chk("rst.valid", bus.o_data_valid, 1'b0);
        chk("rst.timeout", bus.o_timeout, 1'b0);
        chk("rst.cnt", bus.o_frame_cnt, '0);
        @(negedge sys_clk);
        rst = 1'b0;

        // Rate 1/3, all 3'b101 back-to-back.
        for (int k = 0; k < N; k++) begin syms[k] = 3'b101; rates[k] = 1'b1; end
        send_frame(N, 1'b0);
        exp_a = {128{3'b101}};
        chk("a.frame_const", bus.o_decoder_data_frame, exp_a);
        finish_decode(20, {4{32'hDEADBEEF}}, "a");

        // Rate 1/2 latched at symbol 0; the rate switch at symbol 50 must not matter.
        for (int k = 0; k < N; k++) begin syms[k] = 3'b111; rates[k] = (k >= 50); end
        send_frame(N, 1'b0);
        finish_decode(5, rand128(), "b");

        // Done outside DECODE is ignored.
        @(negedge sys_clk);
        bus.i_decoder_data = rand128();
        bus.i_decoder_done = 1'b1;
        @(negedge sys_clk);
        bus.i_decoder_done = 1'b0;
        chk("idle_done.valid", bus.o_data_valid, 1'b0);
        chk("idle_done.cnt", bus.o_frame_cnt, exp_cnt);
        chk("idle_done.ready", bus.o_sym_ready, 1'b1);

        // Decoder never answers: one timeout pulse after 1023 DECODE cycles.
        for (int k = 0; k < N; k++) begin syms[k] = 3'($urandom); rates[k] = 1'($urandom); end
        send_frame(N, 1'b1);
        chk("t.frame", bus.o_decoder_data_frame, model_frame());
        en_all   = 1'b1;
        tmo_seen = 1'b0;
        for (int c = 2; c <= 1023; c++) begin
            @(negedge sys_clk);
            en_all   = en_all & bus.o_en;
            tmo_seen = tmo_seen | bus.o_timeout;
        end
        chk("t.en_held", en_all, 1'b1);
        chk("t.no_early_tmo", tmo_seen, 1'b0);
        @(negedge sys_clk);
        chk("t.pulse", bus.o_timeout, 1'b1);
        chk("t.en_low", bus.o_en, 1'b0);
        chk("t.ready", bus.o_sym_ready, 1'b1);
        chk("t.cnt", bus.o_frame_cnt, exp_cnt);
        chk("t.frame_zero", bus.o_decoder_data_frame, '0);
        @(negedge sys_clk);
        chk("t.pulse_end", bus.o_timeout, 1'b0);

        // Done on the very cycle the timeout would expire: done wins.
        for (int k = 0; k < N; k++) begin syms[k] = 3'($urandom); rates[k] = 1'($urandom); end
        send_frame(N, 1'b0);
        finish_decode(1023, rand128(), "coin");

        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) begin syms[k] = 3'($urandom); rates[k] = 1'($urandom); end
            send_frame(N, 1'b1);
            finish_decode($urandom_range(1, 40), rand128(), "rnd");
        end

        // Reset after symbol 60 discards the partial frame.
        for (int k = 0; k < N; k++) begin syms[k] = 3'($urandom); rates[k] = 1'($urandom); end
        send_frame(61, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk("mrst.frame", bus.o_decoder_data_frame, '0);
        chk("mrst.en", bus.o_en, 1'b0);
        chk("mrst.data", bus.o_data, '0);
        chk("mrst.valid", bus.o_data_valid, 1'b0);
        chk("mrst.cnt", bus.o_frame_cnt, '0);
        chk("mrst.timeout", bus.o_timeout, 1'b0);
        @(negedge sys_clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin syms[k] = 3'($urandom); rates[k] = 1'($urandom); end
        send_frame(N, 1'b0);
        finish_decode(7, rand128(), "post_rst");

        // Counter wrap 65535 -> 0.
        @(negedge sys_clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge sys_clk);
        release dut.frame_cnt_q;
        exp_cnt = 65535;
        chk("wrap.preload", bus.o_frame_cnt, exp_cnt);
        for (int k = 0; k < N; k++) begin syms[k] = 3'($urandom); rates[k] = 1'($urandom); end
        send_frame(N, 1'b0);
        finish_decode(3, rand128(), "wrap");
        chk("wrap.zero", bus.o_frame_cnt, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_deserializer.md
RX_FRAME_DESERIALIZER -- requirements
Module: rx_frame_deserializer

Interface
REQ-001 SHALL have parameter SYM_W, default 3 (`MAX_CODE_RATE), width in bits of one received channel symbol.
REQ-002 SHALL have parameter SYMS_PER_FRAME, default 128, symbols per frame (one symbol per data bit).
REQ-003 SHALL have parameter DONE_TIMEOUT, default 1023, maximum cycles to wait for decoder completion.
REQ-004 SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_code_rate  input  1  0 = rate 1/2, 1 = rate 1/3.
REQ-007 SHALL have port i_sym  input  SYM_W  received coded symbol, bit 0 = first generator output.
REQ-008 SHALL have port i_sym_valid  input  1  symbol present.
REQ-009 SHALL have port o_sym_ready  output  1  block accepts a symbol this cycle.
REQ-010 SHALL have port o_decoder_data_frame  output  384  packed frame driven to endec i_decoder_data_frame.
REQ-011 SHALL have port o_en  output  1  drives endec en.
REQ-012 SHALL have port i_decoder_data  input  128  decoded bits from endec.
REQ-013 SHALL have port i_decoder_done  input  1  endec completion.
REQ-014 SHALL have port o_data  output  128  captured decoded frame.
REQ-015 SHALL have port o_data_valid  output  1  o_data holds an unread frame.
REQ-016 SHALL have port i_data_ready  input  1  consumer accepts o_data.
REQ-017 SHALL have port o_timeout  output  1  one-cycle pulse on decoder timeout.
REQ-018 SHALL have port o_frame_cnt  output  16  completed frames, wraps 65535 -> 0.

Function
REQ-019 SHALL implement states COLLECT, DECODE, OUTPUT; reset state COLLECT.
REQ-020 SHALL assert o_sym_ready only in COLLECT; a symbol is accepted when i_sym_valid && o_sym_ready.
REQ-021 SHALL write accepted symbol k (0..127) to frame bits [k*3 +: 3]; when the frame's code rate is 0, bit k*3+2 SHALL be written 0.
REQ-022 SHALL latch i_code_rate on acceptance of symbol 0 and use it for the whole frame; changes mid-frame are ignored.
REQ-023 SHALL, on accepting symbol 127, go to DECODE next cycle with o_decoder_data_frame stable until leaving DECODE.
REQ-024 SHALL hold o_en high for every cycle in DECODE and low otherwise.
REQ-025 SHALL, on i_decoder_done in DECODE, capture i_decoder_data into o_data, set o_data_valid, increment o_frame_cnt, and enter OUTPUT next cycle.
REQ-026 SHALL ignore i_decoder_done outside DECODE.
REQ-027 SHALL count DECODE cycles; if DONE_TIMEOUT cycles elapse without i_decoder_done, it SHALL pulse o_timeout for one cycle, return to COLLECT, clear the symbol index, and leave o_frame_cnt unchanged.
REQ-028 SHALL, in OUTPUT, clear o_data_valid and return to COLLECT on the cycle after i_data_ready && o_data_valid; o_data SHALL remain stable until then.
REQ-029 SHALL, if i_decoder_done and the timeout expiry coincide, treat done as winning: no o_timeout pulse.
REQ-030 SHALL zero the frame register on entry to COLLECT so unused bits read 0.

Reset
REQ-031 SHALL, on rst asserted (asynchronously): state COLLECT, symbol index 0, timeout counter 0, o_decoder_data_frame 0, o_en 0, o_data 0, o_data_valid 0, o_timeout 0, o_frame_cnt 0, latched rate 0.
REQ-032 SHALL, on rst mid-frame or mid-DECODE, discard partial data; the first symbol accepted after release is symbol 0.

Structure
REQ-033 SHALL take SYM_W, frame widths and the state enum type from the shared package / param_def.sv; the symbol counter width is $clog2(SYMS_PER_FRAME).
REQ-034 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-035 Rate 1/3, 128 symbols 3'b101 back-to-back -> frame = 384'h{128{3'b101}}, o_en high the cycle after symbol 127.
REQ-036 Rate 1/2, symbols 3'b111 -> every bit k*3+2 = 0, others 1; rate toggled to 1 at symbol 50 -> no effect.
REQ-037 i_decoder_done after 20 DECODE cycles with i_decoder_data = 128'hDEADBEEF... -> o_data equal, o_data_valid set, o_frame_cnt = 1, o_sym_ready low until i_data_ready.
REQ-038 No i_decoder_done for 1023 cycles -> single o_timeout pulse, o_en low, o_sym_ready high, o_frame_cnt unchanged.
REQ-039 rst pulsed after symbol 60 -> all outputs 0; next 128 symbols form a correct frame.
REQ-040 o_frame_cnt preloaded to 65535 via 65535 frames (or forced) -> next frame wraps to 0.
